// File: rtl/l2_rr_arbiter_pkg.sv
// Shared L2 arbitration configuration and types.
// Used by the round-robin arbiter and its priority-select helper.
package l2_config_and_types;

    localparam int L2_NUM_PORTS = 4;
    localparam int L2_MAX_BURST = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } arb_state_t;

endpackage

// File: rtl/l2_rr_priority_select.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Reusable by any L2 arbiter that keeps its own priority pointer.
module l2_rr_priority_select #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] requests,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     index,
    output logic [NUM_PORTS-1:0] onehot,
    output logic                 any
);

    localparam int POS_W = $clog2(2 * NUM_PORTS);

    logic [NUM_PORTS-1:0]   mask;
    logic [2*NUM_PORTS-1:0] dbl;
    logic [POS_W-1:0]       pos;
    logic [POS_W-1:0]       pos_wrapped;

    // Lower copy only keeps requests at or above ptr; the upper copy covers the wrap.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
            assign mask[gi]   = (IDX_W'(gi) >= ptr);
            assign onehot[gi] = any && (index == IDX_W'(gi));
        end
    endgenerate

    assign dbl = {requests, requests & mask};
    assign any = |requests;

    always_comb begin
        pos = '0;
        for (int i = 2 * NUM_PORTS - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                pos = POS_W'(i);
            end
        end
    end

    assign pos_wrapped = (pos >= POS_W'(NUM_PORTS)) ? pos - POS_W'(NUM_PORTS) : pos;
    assign index       = pos_wrapped[IDX_W-1:0];

endmodule

// File: rtl/l2_rr_arbiter.sv
// Round-robin L2 grant source with registered outputs and optional burst lock.
// Arbitration happens only in IDLE; one bubble cycle separates consecutive grants.
module l2_rr_arbiter
    import l2_config_and_types::*;
#(
    parameter int NUM_PORTS = L2_NUM_PORTS,
    parameter int MAX_BURST = L2_MAX_BURST,
    parameter int BURST_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         requests,
    input  logic                         strobe,
    input  logic [BURST_W-1:0]           burst_len,
    output logic [$clog2(NUM_PORTS)-1:0] grantee_i,
    output logic [NUM_PORTS-1:0]         grantee_v,
    output logic                         grantee_valid
);

    localparam int                 IDX_W     = $clog2(NUM_PORTS);
    localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]   LAST_PORT = IDX_W'(NUM_PORTS - 1);

    arb_state_t           state_reg, state_next;
    logic [IDX_W-1:0]     ptr_reg, ptr_next;
    logic [BURST_W-1:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]     grantee_i_reg, grantee_i_next;
    logic [NUM_PORTS-1:0] grantee_v_reg, grantee_v_next;
    logic                 valid_reg, valid_next;

    logic [IDX_W-1:0]     sel_index;
    logic [NUM_PORTS-1:0] sel_onehot;
    logic                 sel_any;
    logic [BURST_W-1:0]   burst_clamped;
    logic                 release_grant;

    l2_rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_select (
        .requests (requests),
        .ptr      (ptr_reg),
        .index    (sel_index),
        .onehot   (sel_onehot),
        .any      (sel_any)
    );

    assign burst_clamped = (burst_len > BURST_CAP) ? BURST_CAP : burst_len;

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        cnt_next       = cnt_reg;
        grantee_i_next = grantee_i_reg;
        grantee_v_next = grantee_v_reg;
        valid_next     = valid_reg;
        release_grant  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sel_any) begin
                    state_next     = GRANT;
                    grantee_i_next = sel_index;
                    grantee_v_next = sel_onehot;
                    valid_next     = 1'b1;
                end
            end
            GRANT: begin
                if (strobe) begin
                    if (burst_clamped == '0) begin
                        release_grant = 1'b1;
                    end else begin
                        cnt_next   = burst_clamped;
                        state_next = BURST;
                    end
                end
            end
            BURST: begin
                if (strobe) begin
                    if (cnt_reg == BURST_W'(1)) begin
                        release_grant = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - BURST_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // grantee_i keeps its last value across the idle bubble.
        if (release_grant) begin
            state_next     = IDLE;
            cnt_next       = '0;
            valid_next     = 1'b0;
            grantee_v_next = '0;
            ptr_next       = (grantee_i_reg == LAST_PORT) ? '0 : grantee_i_reg + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            cnt_reg       <= '0;
            grantee_i_reg <= '0;
            grantee_v_reg <= '0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            cnt_reg       <= cnt_next;
            grantee_i_reg <= grantee_i_next;
            grantee_v_reg <= grantee_v_next;
            valid_reg     <= valid_next;
        end
    end

    assign grantee_i     = grantee_i_reg;
    assign grantee_v     = grantee_v_reg;
    assign grantee_valid = valid_reg;

`ifndef SYNTHESIS
    a_grantee_holds_request: assert property (@(posedge clk) disable iff (rst)
        valid_reg |-> requests[grantee_i_reg])
        else $warning("l2_rr_arbiter: grantee dropped its request before release");

    a_no_strobe_when_idle: assert property (@(posedge clk) disable iff (rst)
        strobe |-> valid_reg)
        else $warning("l2_rr_arbiter: strobe ignored while no grant is active");
`endif

endmodule
